// File: rtl/pipe_ex_mem_reg_pkg.sv
// Shared definitions for the EX->MEM stage: access-size codes, NOP register,
// stall bus polarity and the byte-enable mask helper.
package pipe_ex_mem_reg_pkg;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2,
    MSIZE_D = 2'd3
  } msize_e;

  localparam int   NOP_REG       = 0;
  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;

  // Right-aligned byte mask covering one access of the given size.
  function automatic logic [7:0] be_mask(input logic [1:0] msize);
    case (msize)
      MSIZE_B: be_mask = 8'h01;
      MSIZE_H: be_mask = 8'h03;
      MSIZE_W: be_mask = 8'h0F;
      default: be_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment: misalignment detect, byte-enable generation
// and store-data shift into the addressed byte lane.
module mem_lane_align #(
  parameter int DATA_W = 32
) (
  input  logic                mre,
  input  logic                mwe,
  input  logic [1:0]          msize,
  input  logic [2:0]          alo,
  input  logic [DATA_W-1:0]   wdata,
  output logic                misalign,
  output logic [DATA_W/8-1:0] mbe,
  output logic [DATA_W-1:0]   wdata_al
);
  import pipe_ex_mem_reg_pkg::*;

  localparam int NB   = DATA_W / 8;
  localparam int LO_W = $clog2(NB);

  logic            access;
  logic            addr_bad;
  logic            size_bad;
  logic [2:0]      amask;
  logic [7:0]      full_mask;
  logic [LO_W-1:0] lo;

  always_comb begin
    access    = mre | mwe;
    amask     = (3'd1 << msize) - 3'd1;
    addr_bad  = |(alo & amask);
    // A dword has no lane to land in on a 32-bit datapath.
    size_bad  = (DATA_W == 32) && (msize == MSIZE_D);
    misalign  = access && (addr_bad || size_bad || (mre && mwe));
    lo        = alo[LO_W-1:0];
    full_mask = be_mask(msize);
    mbe       = '0;
    if (access && !misalign)
      mbe = NB'(full_mask << lo);
    wdata_al = wdata;
    if (mwe && !misalign)
      wdata_al = wdata << {lo, 3'b000};
  end

endmodule

// File: rtl/pipe_ex_mem_reg.sv
// EX->MEM pipeline register with flush, stall/bubble from the ctrl stall bus,
// and registered byte enables / misalignment fault. PIPE_EX_MEM_PERF_EN adds
// saturating bubble/hold counters.
module pipe_ex_mem_reg #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int MADDR_W   = 32,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [REG_AW-1:0]   ex_waddr,
  input  logic                ex_we,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_mre,
  input  logic                ex_mwe,
  input  logic [1:0]          ex_msize,
  input  logic                ex_msext,
  input  logic [DATA_W-1:0]   ex_mwdata,
  input  logic [MADDR_W-1:0]  ex_maddr,
  input  logic [STALL_W-1:0]  ctrl_stall,
  input  logic                ctrl_flush,
  output logic                mem_valid,
  output logic [REG_AW-1:0]   mem_waddr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_mre,
  output logic                mem_mwe,
  output logic [1:0]          mem_msize,
  output logic                mem_msext,
  output logic [DATA_W/8-1:0] mem_mbe,
  output logic [DATA_W-1:0]   mem_mwdata,
  output logic [MADDR_W-1:0]  mem_maddr,
  output logic                mem_misalign
`ifdef PIPE_EX_MEM_PERF_EN
  ,
  output logic [31:0]         perf_bubble_cnt,
  output logic [31:0]         perf_hold_cnt
`endif
);
  import pipe_ex_mem_reg_pkg::*;

  logic                s_stall, n_stall;
  logic                bubble, hold, nop_sel, load_sel;
  logic                al_mis;
  logic [DATA_W/8-1:0] al_mbe;
  logic [DATA_W-1:0]   al_wdata;
  logic                unused_stall;

  assign s_stall      = ctrl_stall[STAGE_IDX];
  assign n_stall      = ctrl_stall[STAGE_IDX+1];
  assign unused_stall = ^ctrl_stall;

  assign bubble   = (s_stall == STALL_ENABLE) && (n_stall == STALL_DISABLE);
  assign hold     = !ctrl_flush && (s_stall == STALL_ENABLE) && (n_stall == STALL_ENABLE);
  // An invalid payload on a load cycle becomes a NOP rather than stale fields.
  assign nop_sel  = rst || ctrl_flush || bubble || ((s_stall == STALL_DISABLE) && !ex_valid);
  assign load_sel = (s_stall == STALL_DISABLE);

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .mre      (ex_mre),
    .mwe      (ex_mwe),
    .msize    (ex_msize),
    .alo      (ex_maddr[2:0]),
    .wdata    (ex_mwdata),
    .misalign (al_mis),
    .mbe      (al_mbe),
    .wdata_al (al_wdata)
  );

  always_ff @(posedge clk) begin
    if (nop_sel) begin
      mem_valid    <= 1'b0;
      mem_waddr    <= REG_AW'(NOP_REG);
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      mem_mre      <= 1'b0;
      mem_mwe      <= 1'b0;
      mem_msize    <= '0;
      mem_msext    <= 1'b0;
      mem_mbe      <= '0;
      mem_mwdata   <= '0;
      mem_maddr    <= '0;
      mem_misalign <= 1'b0;
    end else if (load_sel) begin
      mem_valid    <= 1'b1;
      mem_waddr    <= ex_waddr;
      mem_we       <= ex_we;
      mem_wdata    <= ex_wdata;
      // A faulting access must not reach memory; the exception unit takes it.
      mem_mre      <= ex_mre & ~al_mis;
      mem_mwe      <= ex_mwe & ~al_mis;
      mem_msize    <= ex_msize;
      mem_msext    <= ex_msext;
      mem_mbe      <= al_mbe;
      mem_mwdata   <= al_wdata;
      mem_maddr    <= ex_maddr;
      mem_misalign <= al_mis;
    end
  end

`ifdef PIPE_EX_MEM_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble_cnt <= '0;
      perf_hold_cnt   <= '0;
    end else begin
      if ((ctrl_flush || bubble) && !(&perf_bubble_cnt))
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (hold && !(&perf_hold_cnt))
        perf_hold_cnt <= perf_hold_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ex_mem_reg.sv
// Scoreboard bench for pipe_ex_mem_reg: directed vectors push hand-computed
// expectations, a monitor pops and compares one entry per clock.
module tb_pipe_ex_mem_reg;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [5:0] RUN = 6'b000000;
  localparam logic [5:0] BUB = 6'b001000;
  localparam logic [5:0] HLD = 6'b011000;

  typedef struct packed {
    logic        valid;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic        mre;
    logic        mwe;
    logic [1:0]  msize;
    logic        msext;
    logic [3:0]  mbe;
    logic [31:0] mwdata;
    logic [31:0] maddr;
    logic        misalign;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_we = 1'b0, ex_mre = 1'b0, ex_mwe = 1'b0, ex_msext = 1'b0;
  logic [4:0]  ex_waddr = '0;
  logic [31:0] ex_wdata = '0, ex_mwdata = '0, ex_maddr = '0;
  logic [1:0]  ex_msize = '0;
  logic [5:0]  ctrl_stall = '0;
  logic        ctrl_flush = 1'b0;
  logic        mem_valid, mem_we, mem_mre, mem_mwe, mem_msext, mem_misalign;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata, mem_mwdata, mem_maddr;
  logic [1:0]  mem_msize;
  logic [3:0]  mem_mbe;
`ifdef PIPE_EX_MEM_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_hold_cnt;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  pipe_ex_mem_reg dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_waddr(ex_waddr), .ex_we(ex_we), .ex_wdata(ex_wdata),
    .ex_mre(ex_mre), .ex_mwe(ex_mwe), .ex_msize(ex_msize), .ex_msext(ex_msext),
    .ex_mwdata(ex_mwdata), .ex_maddr(ex_maddr),
    .ctrl_stall(ctrl_stall), .ctrl_flush(ctrl_flush),
    .mem_valid(mem_valid), .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_mre(mem_mre), .mem_mwe(mem_mwe), .mem_msize(mem_msize), .mem_msext(mem_msext),
    .mem_mbe(mem_mbe), .mem_mwdata(mem_mwdata), .mem_maddr(mem_maddr),
    .mem_misalign(mem_misalign)
`ifdef PIPE_EX_MEM_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_hold_cnt(perf_hold_cnt)
`endif
  );

  function automatic exp_t mk(input logic v, input logic [4:0] wa, input logic we,
                              input logic [31:0] wd, input logic mre, input logic mwe,
                              input logic [1:0] ms, input logic sx, input logic [3:0] be,
                              input logic [31:0] mwd, input logic [31:0] ma, input logic mis);
    mk = {v, wa, we, wd, mre, mwe, ms, sx, be, mwd, ma, mis};
  endfunction

  localparam exp_t NOP = '0;

  task automatic vec(input logic r, input logic [5:0] st, input logic fl,
                     input logic v, input logic [4:0] wa, input logic we, input logic [31:0] wd,
                     input logic mre, input logic mwe, input logic [1:0] ms, input logic sx,
                     input logic [31:0] mwd, input logic [31:0] ma,
                     input string tag, input exp_t e);
    @(negedge clk);
    rst = r; ctrl_stall = st; ctrl_flush = fl;
    ex_valid = v; ex_waddr = wa; ex_we = we; ex_wdata = wd;
    ex_mre = mre; ex_mwe = mwe; ex_msize = ms; ex_msext = sx;
    ex_mwdata = mwd; ex_maddr = ma;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: one expectation per active edge, sampled 1 time unit later.
  initial begin
    exp_t e, a;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = mk(mem_valid, mem_waddr, mem_we, mem_wdata, mem_mre, mem_mwe, mem_msize,
               mem_msext, mem_mbe, mem_mwdata, mem_maddr, mem_misalign);
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s: got v=%b wa=%0d we=%b wd=%h mre=%b mwe=%b ms=%0d sx=%b be=%h mwd=%h ma=%h mis=%b want v=%b wa=%0d we=%b wd=%h mre=%b mwe=%b ms=%0d sx=%b be=%h mwd=%h ma=%h mis=%b",
                   t, a.valid, a.waddr, a.we, a.wdata, a.mre, a.mwe, a.msize, a.msext, a.mbe,
                   a.mwdata, a.maddr, a.misalign, e.valid, e.waddr, e.we, e.wdata, e.mre,
                   e.mwe, e.msize, e.msext, e.mbe, e.mwdata, e.maddr, e.misalign);
        end
      end
    end
  end

  initial begin
    exp_t la;
    la = mk(Y, 5'd9, Y, 32'h99, N, Y, 2'd2, N, 4'hF, 32'hCAFEF00D, 32'h2000, N);

    vec(Y, RUN, N, Y, 5'd3, Y, 32'h1, Y, N, 2'd2, N, 32'h1, 32'h4, "reset", NOP);
    vec(N, RUN, N, Y, 5'd0, N, 32'h0, N, Y, 2'd2, N, 32'hAABBCCDD, 32'h1004, "st_word",
        mk(Y, 5'd0, N, 32'h0, N, Y, 2'd2, N, 4'hF, 32'hAABBCCDD, 32'h1004, N));
    vec(N, RUN, N, Y, 5'd0, N, 32'h0, N, Y, 2'd0, N, 32'hEE, 32'h1003, "st_byte",
        mk(Y, 5'd0, N, 32'h0, N, Y, 2'd0, N, 4'h8, 32'hEE000000, 32'h1003, N));
    vec(N, RUN, N, Y, 5'd7, Y, 32'h12345678, Y, N, 2'd1, Y, 32'h55, 32'h1001, "ld_half_mis",
        mk(Y, 5'd7, Y, 32'h12345678, N, N, 2'd1, Y, 4'h0, 32'h55, 32'h1001, Y));
    vec(N, RUN, N, Y, 5'd3, Y, 32'h0, Y, N, 2'd1, Y, 32'h66, 32'h1002, "ld_half",
        mk(Y, 5'd3, Y, 32'h0, Y, N, 2'd1, Y, 4'hC, 32'h66, 32'h1002, N));
    vec(N, RUN, N, Y, 5'd0, N, 32'h0, N, Y, 2'd1, N, 32'hBEEF, 32'h1002, "st_half",
        mk(Y, 5'd0, N, 32'h0, N, Y, 2'd1, N, 4'hC, 32'hBEEF0000, 32'h1002, N));
    vec(N, RUN, N, Y, 5'd2, Y, 32'h0, Y, N, 2'd0, N, 32'h0, 32'h1001, "ld_byte",
        mk(Y, 5'd2, Y, 32'h0, Y, N, 2'd0, N, 4'h2, 32'h0, 32'h1001, N));
    vec(N, RUN, N, Y, 5'd2, Y, 32'h0, Y, N, 2'd3, N, 32'h0, 32'h1000, "ld_dword32",
        mk(Y, 5'd2, Y, 32'h0, N, N, 2'd3, N, 4'h0, 32'h0, 32'h1000, Y));
    vec(N, RUN, N, Y, 5'd0, N, 32'h0, Y, Y, 2'd2, N, 32'h11, 32'h1000, "rd_and_wr",
        mk(Y, 5'd0, N, 32'h0, N, N, 2'd2, N, 4'h0, 32'h11, 32'h1000, Y));
    vec(N, RUN, N, Y, 5'd0, N, 32'h0, N, Y, 2'd2, N, 32'h77, 32'h1002, "st_word_mis",
        mk(Y, 5'd0, N, 32'h0, N, N, 2'd2, N, 4'h0, 32'h77, 32'h1002, Y));
    vec(N, RUN, N, Y, 5'd6, Y, 32'hDEAD, N, N, 2'd1, N, 32'h44, 32'h1003, "alu_only",
        mk(Y, 5'd6, Y, 32'hDEAD, N, N, 2'd1, N, 4'h0, 32'h44, 32'h1003, N));
    vec(N, RUN, N, N, 5'd5, Y, 32'h1, N, Y, 2'd2, N, 32'h33, 32'h1000, "invalid", NOP);
    vec(N, RUN, N, Y, 5'd9, Y, 32'h99, N, Y, 2'd2, N, 32'hCAFEF00D, 32'h2000, "load_a", la);
    for (int i = 0; i < 3; i++)
      vec(N, HLD, N, Y, 5'd1, Y, 32'h5, Y, N, 2'd2, N, 32'h0, 32'h4000, "hold", la);
    vec(N, BUB, N, Y, 5'd1, Y, 32'h5, Y, N, 2'd2, N, 32'h0, 32'h4000, "bubble", NOP);
    vec(N, RUN, N, Y, 5'd9, Y, 32'h99, N, Y, 2'd2, N, 32'hCAFEF00D, 32'h2000, "load_a", la);
    vec(N, HLD, Y, Y, 5'd1, Y, 32'h5, Y, N, 2'd2, N, 32'h0, 32'h4000, "flush_hold", NOP);
    vec(N, RUN, N, Y, 5'd9, Y, 32'h99, N, Y, 2'd2, N, 32'hCAFEF00D, 32'h2000, "load_a", la);
    vec(N, RUN, Y, Y, 5'd1, Y, 32'h5, Y, N, 2'd2, N, 32'h0, 32'h4000, "flush_run", NOP);
    vec(N, RUN, N, Y, 5'd9, Y, 32'h99, N, Y, 2'd2, N, 32'hCAFEF00D, 32'h2000, "load_a", la);
    vec(Y, HLD, N, Y, 5'd1, Y, 32'h5, Y, N, 2'd2, N, 32'h0, 32'h4000, "reset_hold", NOP);

    // Counter scenario: 2 bubbles + 1 flush + 4 holds after a reset.
    vec(N, BUB, N, Y, 5'd1, Y, 32'h5, Y, N, 2'd2, N, 32'h0, 32'h4000, "pc_bubble", NOP);
    vec(N, BUB, N, Y, 5'd1, Y, 32'h5, Y, N, 2'd2, N, 32'h0, 32'h4000, "pc_bubble", NOP);
    vec(N, RUN, Y, Y, 5'd1, Y, 32'h5, Y, N, 2'd2, N, 32'h0, 32'h4000, "pc_flush", NOP);
    for (int i = 0; i < 4; i++)
      vec(N, HLD, N, Y, 5'd1, Y, 32'h5, Y, N, 2'd2, N, 32'h0, 32'h4000, "pc_hold", NOP);
`ifdef PIPE_EX_MEM_PERF_EN
    @(posedge clk);
    #2;
    checks++;
    if (perf_bubble_cnt !== 32'd3) begin
      failures++;
      $display("FAIL perf_bubble: got %0d want 3", perf_bubble_cnt);
    end
    checks++;
    if (perf_hold_cnt !== 32'd4) begin
      failures++;
      $display("FAIL perf_hold: got %0d want 4", perf_hold_cnt);
    end
`endif
    vec(N, RUN, N, N, 5'd0, N, 32'h0, N, N, 2'd0, N, 32'h0, 32'h0, "idle", NOP);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ex_mem_reg.md
Name: pipe_ex_mem_reg

Overview:
- Parametrised EX→MEM pipeline register, successor to the fixed-width EX/MEM latch.
- Adds a payload valid bit, a flush input, and byte/half/word memory access size.
- Generates byte enables and flags misaligned accesses, all registered at the stage boundary.
- Stall/bubble semantics are driven by the shared ctrl stall bus, with the stage index parametrised so the same block serves any stage boundary.

Parameters:
- DATA_W, 32, register-file and memory data width; must be 32 or 64.
- REG_AW, 5, register address width.
- MADDR_W, 32, memory address width.
- STALL_W, 6, width of ctrl stall bus.
- STAGE_IDX, 3, index of this stage's bit in the stall bus; STAGE_IDX+1 < STALL_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  EX payload valid
- ex_waddr  in  REG_AW  destination register
- ex_we  in  1  register write enable
- ex_wdata  in  DATA_W  register write data
- ex_mre  in  1  memory read request
- ex_mwe  in  1  memory write request
- ex_msize  in  2  access size: 0 byte, 1 half, 2 word, 3 dword (DATA_W=64 only)
- ex_msext  in  1  sign-extend load result
- ex_mwdata  in  DATA_W  store data, right-aligned
- ex_maddr  in  MADDR_W  memory byte address
- ctrl_stall  in  STALL_W  stall bus, 1 = stall
- ctrl_flush  in  1  kill payload entering MEM
- mem_valid  out  1
- mem_waddr  out  REG_AW
- mem_we  out  1
- mem_wdata  out  DATA_W
- mem_mre  out  1
- mem_mwe  out  1
- mem_msize  out  2
- mem_msext  out  1
- mem_mbe  out  DATA_W/8  byte enables
- mem_mwdata  out  DATA_W  store data shifted to byte lane
- mem_maddr  out  MADDR_W
- mem_misalign  out  1  registered misalignment fault

Behaviour:
- Notation: s = ctrl_stall[STAGE_IDX], n = ctrl_stall[STAGE_IDX+1].
- One register stage, latency 1 cycle.
- Priority per posedge clk: rst > ctrl_flush > bubble (s=1, n=0) > load (s=0) > hold (s=1, n=1).
- Reset and bubble load the NOP value on every output:
  - 0 on every output, including valid, mbe and misalign.
  - mem_waddr = 0 (NOP register).
- Flush also loads the NOP value.
  - Flush wins over hold: a flush during s=n=1 still clears the register.
- Load:
  - Captures all ex_* fields.
  - mem_valid = ex_valid.
  - When ex_valid=0, loads NOP regardless of other inputs.
- Hold: all outputs unchanged.
- Misalignment:
  - Defined as ex_maddr mod (1<<ex_msize) != 0 with (ex_mre|ex_mwe)=1.
  - On a load with misalignment: mem_misalign=1, mem_mre=0, mem_mwe=0, mem_mbe=0.
  - All other fields are captured normally; the exception unit consumes the fault.
- ex_msize=3 with DATA_W=32 is treated as misaligned.
- Byte enables, computed from lo = ex_maddr[log2(DATA_W/8)-1:0]:
  - mem_mbe = ((1<<(1<<msize))-1) << lo, only when mre|mwe and aligned; else 0.
- Store data: mem_mwdata = ex_mwdata << (8*lo) when mwe and aligned; else ex_mwdata unchanged.
- Both mre and mwe asserted: illegal; load captures both and sets mem_misalign=1 with mre/mwe cleared.
- Reset asserted mid-hold clears immediately at the next edge.

Optional Feature:
- Macro: PIPE_EX_MEM_PERF_EN.
- When defined, adds two outputs and two counters:
  - perf_bubble_cnt, 32-bit, counts cycles taking the bubble or flush path.
  - perf_hold_cnt, 32-bit, counts hold cycles.
  - Both counters saturate at all-ones and clear on rst.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Size encodings: MSIZE_B, MSIZE_H, MSIZE_W, MSIZE_D.
  - NOP register address constant.
  - STALL_ENABLE/DISABLE constants.
  - Helper function for byte-enable mask.
- Sub-module mem_lane_align: combinational misalign detect, mbe generation and store shift.
  - Instantiated once; the register stage stays pure sequential.

Test Plan:
- Load path: s=0; word store to addr 0x1004, data 0xAABBCCDD → next cycle mem_mwe=1, mem_mbe=4'b1111, mem_mwdata=0xAABBCCDD, mem_valid=1.
- Byte lane: byte store, addr 0x1003, data 0x000000EE → mem_mbe=4'b1000, mem_mwdata=0xEE000000.
- Misalign: half load at addr 0x1001 → mem_misalign=1, mem_mre=0, mem_mbe=0, mem_maddr=0x1001.
- Stall semantics:
  - s=1, n=0 → NOP outputs (mem_waddr=0, mem_we=0).
  - s=1, n=1 for 3 cycles → outputs frozen at the prior value.
- Flush during hold: s=n=1 with ctrl_flush=1 → outputs NOP next cycle. Reset while loaded → all outputs 0 at the next edge.
- PIPE_EX_MEM_PERF_EN: 2 bubbles + 1 flush + 4 holds → perf_bubble_cnt=3, perf_hold_cnt=4.
